sum_normalizer: RTL

//  Consumer end of the leading-one interface: takes the 20-bit unsigned accumulator sum
//  and the registered leading-one position from the detector, left-normalizes the sum,

---
 rtl/sum_normalizer.sv | 116 +++++++++++
 1 files changed

// File: rtl/sum_normalizer.sv
// Left-normalizes the accumulator sum using the registered leading-one position,
// rounds to MANT_W bits (nearest-even) and queues {mant, exp, zero_flag} for output.
module sum_normalizer #(
    parameter int SUM_W     = 20,
    parameter int POS_W     = 5,
    parameter int MANT_W    = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  unsign_sum,
    input  logic [POS_W-1:0]  leading_one,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant,
    output logic [POS_W-1:0]  exp,
    output logic              zero_flag,
    output logic              lod_err
);
    localparam int STAGES = 1;
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [POS_W-1:0]  exp;
        logic              zero;
    } res_t;

    logic [STAGES:0]    vld_pipe;
    logic [SUM_W-1:0]   sum_s0;
    logic [SUM_W-1:0]   norm_s1;
    logic [POS_W-1:0]   lo_s1;
    logic               zero_s1;

    res_t               mem [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;

    logic               accept, push, pop;
    logic [POS_W-1:0]   shamt;
    logic [SUM_W-1:0]   norm_c, above_c;
    logic               lod_bad;
    logic [MANT_W-1:0]  m;
    logic               g, s, up;
    res_t               res_c, head;

    // Sums in S0/S1 already own a queue slot, so nothing accepted can be dropped.
    assign credit_used = {1'b0, count}
                       + {{CNT_W{1'b0}}, vld_pipe[0]}
                       + {{CNT_W{1'b0}}, vld_pipe[1]};
    assign in_ready = !rst && (credit_used < (CNT_W+1)'(OUT_DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = vld_pipe[STAGES];
    assign out_valid = (count != '0);
    assign pop      = out_valid && out_ready;

    // S1: the detector result for sum_s0 arrives this cycle.
    assign shamt   = POS_W'(SUM_W-1) - leading_one;
    assign norm_c  = sum_s0 << shamt;
    assign above_c = sum_s0 >> leading_one;
    assign lod_bad = (sum_s0 != '0) && (!above_c[0] || (|above_c[SUM_W-1:1]));

    // S2: round-to-nearest-even on the normalized sum.
    assign m  = norm_s1[SUM_W-1 -: MANT_W];
    assign g  = norm_s1[SUM_W-1-MANT_W];
    assign s  = |norm_s1[SUM_W-2-MANT_W:0];
    assign up = g && (s || m[0]);

    always_comb begin
        res_c = '0;
        if (zero_s1) begin
            res_c.zero = 1'b1;
        end else if (up && (&m)) begin
            res_c.mant = {1'b1, {(MANT_W-1){1'b0}}};
            res_c.exp  = lo_s1 + POS_W'(1);
        end else begin
            res_c.mant = m + {{(MANT_W-1){1'b0}}, up};
            res_c.exp  = lo_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lod_err  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (vld_pipe[0] && lod_bad) lod_err <= 1'b1;
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) sum_s0 <= unsign_sum;
        norm_s1 <= norm_c;
        lo_s1   <= leading_one;
        zero_s1 <= (sum_s0 == '0);
        if (push) mem[wr_ptr] <= res_c;
    end

    assign head      = mem[rd_ptr];
    assign mant      = out_valid ? head.mant : '0;
    assign exp       = out_valid ? head.exp  : '0;
    assign zero_flag = out_valid ? head.zero : 1'b0;
endmodule
